// File: rtl/mod_pow.sv
// mod_pow: sequential modular exponentiation, res = x^y mod n (unsigned).
// There is no start strobe. A change of the operand triple, seen while idle,
// starts a new run. The base is first reduced (1*x mod n, W cycles). Then
// right-to-left square-and-multiply runs over the exponent bits (W cycles per
// bit), using two bit-serial interleaved modular multipliers in parallel.
// Optional feature macro: MODPOW_EARLY_EXIT_EN. When defined, the exponent
// loop stops after the highest set bit of y. The result is the same; only the
// latency changes.
module mod_pow #(
  parameter int mbit = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [mbit:0] modpow_x,
  input  logic [mbit:0] modpow_y,
  input  logic [mbit:0] modpow_n,
  output logic [mbit:0] modpow_res,
  output logic          modpow_busy
);

  localparam int W  = mbit + 1;
  localparam int PW = W + 2;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0] BIT_TOP = CW'(mbit);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REDUCE = 2'd1;
  localparam logic [1:0] S_EXP    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  lx_q, lx_d, ly_q, ly_d, ln_q, ln_d;
  logic [W-1:0]  base_q, base_d, acc_q, acc_d, res_q, res_d;
  logic [PW-1:0] pa_q, pa_d, ps_q, ps_d;
  logic [CW-1:0] bit_q, bit_d, exp_q, exp_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] step_red, step_acc, step_sq;
  logic [W-1:0]  acc_next;
  logic          last_bit;

  // One interleaved modmul step: p' = (2p + b*a) mod n, given p < n and a < n.
  function automatic logic [PW-1:0] mm_step(input logic [PW-1:0] p,
                                            input logic [W-1:0]  a,
                                            input logic          b,
                                            input logic [W-1:0]  n);
    logic [PW-1:0] t;
    logic [PW-1:0] nn;
    nn = {2'b00, n};
    t  = {p[PW-2:0], 1'b0};
    if (t >= nn) t = t - nn;
    if (b) begin
      t = t + {2'b00, a};
      if (t >= nn) t = t - nn;
    end
    return t;
  endfunction

  // Datapath steps: base reduction is 1*x, with x scanned MSB first. The
  // exponent step runs acc*base and base*base, both scanning the bits of base.
  always_comb begin
    step_red = mm_step(pa_q, W'(1), lx_q[bit_q], ln_q);
    step_acc = mm_step(pa_q, acc_q, base_q[bit_q], ln_q);
    step_sq  = mm_step(ps_q, base_q, base_q[bit_q], ln_q);
  end

  // Next-state logic for the IDLE / REDUCE / EXP sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    lx_d     = lx_q;
    ly_d     = ly_q;
    ln_d     = ln_q;
    base_d   = base_q;
    acc_d    = acc_q;
    res_d    = res_q;
    pa_d     = pa_q;
    ps_d     = ps_q;
    bit_d    = bit_q;
    exp_d    = exp_q;
    busy_d   = busy_q;
    acc_next = acc_q;
    last_bit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ({modpow_x, modpow_y, modpow_n} != {lx_q, ly_q, ln_q}) begin
          lx_d = modpow_x;
          ly_d = modpow_y;
          ln_d = modpow_n;
          if (modpow_n < W'(2)) begin
            res_d = '0;
          end else begin
            busy_d  = 1'b1;
            state_d = S_REDUCE;
            bit_d   = BIT_TOP;
            pa_d    = '0;
            ps_d    = '0;
          end
        end
      end

      S_REDUCE: begin
        pa_d = step_red;
        if (bit_q == '0) begin
          base_d  = step_red[W-1:0];
          acc_d   = W'(1);
          pa_d    = '0;
          ps_d    = '0;
          bit_d   = BIT_TOP;
          exp_d   = '0;
          state_d = S_EXP;
`ifdef MODPOW_EARLY_EXIT_EN
          if (ly_q == '0) begin
            res_d   = W'(1);
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
`endif
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end

      S_EXP: begin
        pa_d = step_acc;
        ps_d = step_sq;
        if (bit_q == '0) begin
          acc_next = ly_q[exp_q] ? step_acc[W-1:0] : acc_q;
          acc_d    = acc_next;
          base_d   = step_sq[W-1:0];
          pa_d     = '0;
          ps_d     = '0;
          bit_d    = BIT_TOP;
          last_bit = (exp_q == BIT_TOP);
`ifdef MODPOW_EARLY_EXIT_EN
          if (((ly_q >> exp_q) >> 1) == '0) last_bit = 1'b1;
`endif
          if (last_bit) begin
            res_d   = acc_next;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            exp_d = exp_q + 1'b1;
          end
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers, asynchronously cleared; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= S_IDLE;
      lx_q    <= '0;
      ly_q    <= '0;
      ln_q    <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      pa_q    <= '0;
      ps_q    <= '0;
      bit_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      ln_q    <= ln_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      pa_q    <= pa_d;
      ps_q    <= ps_d;
      bit_q   <= bit_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
    end
  end

  assign modpow_res  = res_q;
  assign modpow_busy = busy_q;

endmodule

// File: tb/tb_mod_pow.sv
// tb_mod_pow: scoreboard bench for mod_pow (W = 64).
// The stimulus process pushes the expected result and latency for each
// operand set that the engine will compute. A monitor process pops one entry
// at each busy fall and compares it with the outputs.
module tb_mod_pow;

  localparam int MBIT  = 63;
  localparam int W     = MBIT + 1;
  localparam int LIMIT = 20000;

  logic         clk;
  logic         rst;
  logic [W-1:0] x, y, n;
  logic [W-1:0] res;
  logic         busy;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  mod_pow #(.mbit(MBIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .modpow_x    (x),
    .modpow_y    (y),
    .modpow_n    (n),
    .modpow_res  (res),
    .modpow_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference: plain square-and-multiply using wide multiplication and %.
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] bx, input logic [W-1:0] ey,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] r, b, mm;
    if (m < 2) return '0;
    mm = {{W{1'b0}}, m};
    r  = 1;
    b  = {{W{1'b0}}, bx} % mm;
    for (int i = 0; i < W; i++) begin
      if (ey[i]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_lat(input logic [W-1:0] ey);
`ifdef MODPOW_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < W; i++) if (ey[i]) msb = i;
    return W + W * (msb + 1);
`else
    return W + W * W;
`endif
  endfunction

  task automatic expect_push(input string name, input logic [W-1:0] r, input logic [W-1:0] ey);
    exp_t e;
    e.res  = r;
    e.lat  = ref_lat(ey);
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic apply(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic [W-1:0] an);
    @(posedge clk);
    #1;
    x = ax;
    y = ay;
    n = an;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || busy) && k < LIMIT) begin
      @(posedge clk);
      k++;
    end
    if (k >= LIMIT) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected completion", name, k);
      sb_q.delete();
    end
  endtask

  // Monitor: count busy cycles, and check each completed run against the queue.
  initial begin : monitor
    exp_t e;
    logic busy_prev;
    int   cnt;
    busy_prev = 1'b0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_prev = 1'b0;
        cnt       = 0;
      end else begin
        if (busy) cnt++;
        if (busy_prev && !busy) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: result %0d with empty scoreboard", res);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_res"}, res, e.res);
            check({e.name, "_lat"}, W'(cnt), W'(e.lat));
          end
          cnt = 0;
        end
        busy_prev = busy;
      end
    end
  end

  initial begin : stim
    logic [W-1:0] rx, ry, rn;
    logic         seen;

    rst = 1'b0;
    x = '0;
    y = '0;
    n = '0;
    #12;
    check("reset_res", res, '0);
    check("reset_busy", W'(busy), '0);
    @(negedge clk);
    rst = 1'b1;

    // All-zero operands after reset: no run.
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= busy;
    end
    check("zero_inputs_busy", W'(seen), '0);
    check("zero_inputs_res", res, '0);

    // Large 64-bit vector, then hold inputs: busy must stay low.
    expect_push("plan_big", 64'd180691, 64'd1567911045903664193);
    apply(64'd992274341492776796, 64'd1567911045903664193, 64'd4275095120893583027);
    wait_idle("plan_big");
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= busy;
    end
    check("plan_big_hold_busy", W'(seen), '0);
    check("plan_big_hold_res", res, 64'd180691);

    expect_push("pow_4_13", 64'd445, 64'd13);
    apply(64'd4, 64'd13, 64'd497);
    wait_idle("pow_4_13");

    expect_push("exp_zero", 64'd1, 64'd0);
    apply(64'd4, 64'd0, 64'd497);
    wait_idle("exp_zero");

    expect_push("base_ge_mod", 64'd3, 64'd1);
    apply(64'd10, 64'd1, 64'd7);
    wait_idle("base_ge_mod");

    // n = 0: result cleared one edge after the change, busy never rises.
    apply(64'd5, 64'd3, 64'd0);
    @(posedge clk);
    #1;
    check("mod_zero_res", res, '0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= busy;
    end
    check("mod_zero_busy", W'(seen), '0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 5; i++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      rn = {$urandom, $urandom};
      if (i == 1) rn = {32'd0, $urandom};
      if (i == 2) rx = rn * 3;
      if (rn < 2) rn = rn + 2;
      expect_push($sformatf("rand%0d", i), ref_pow(rx, ry, rn), ry);
      apply(rx, ry, rn);
      wait_idle($sformatf("rand%0d", i));
    end

    // n = 1 following a (most likely) nonzero result.
    apply(64'd123, 64'd45, 64'd1);
    @(posedge clk);
    #1;
    check("mod_one_res", res, '0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= busy;
    end
    check("mod_one_busy", W'(seen), '0);

    // Operand change mid-run: the old run completes, then the new one starts.
    rx = {$urandom, $urandom};
    ry = {$urandom, $urandom};
    rn = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
    expect_push("mid_first", ref_pow(rx, ry, rn), ry);
    apply(rx, ry, rn);
    repeat (200) @(posedge clk);
    #1;
    check("mid_busy", W'(busy), 64'd1);
    rx = {$urandom, $urandom};
    ry = {$urandom, $urandom};
    expect_push("mid_second", ref_pow(rx, ry, rn), ry);
    x = rx;
    y = ry;
    wait_idle("mid_change");

    // Reset mid-run: outputs clear at once, then the run restarts on release.
    rx = {$urandom, $urandom};
    ry = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    rn = {$urandom, $urandom} | 64'h4000_0000_0000_0001;
    expect_push("after_reset", ref_pow(rx, ry, rn), ry);
    apply(rx, ry, rn);
    repeat (300) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_res", res, '0);
    check("midrst_busy", W'(busy), '0);
    @(negedge clk);
    rst = 1'b1;
    wait_idle("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
